// File: rtl/hilo_muldiv.sv
// HI/LO unit: iterative signed/unsigned multiply and divide, MTHI/MTLO writes, MFHI/MFLO read mux.
// Mul/div take WIDTH+1 busy cycles then a done pulse; HI/LO accesses while busy raise stall.
module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [1:0]       rd_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] hilo_out,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = 2 * WIDTH + 1;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic             start, sgn_op, div_op, div_zero;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_hi;
    logic [AW-1:0]    mul_step, div_step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rem;

    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;
    assign stall = busy && ((op != OP_NONE && op != OP_RSVD) || rd_sel == 2'd1 || rd_sel == 2'd2);

    always_comb begin
        case (rd_sel)
            2'd1:    hilo_out = hi_q;
            2'd2:    hilo_out = lo_q;
            default: hilo_out = alu_out;
        endcase
    end

    assign sgn_op   = (op == OP_MULT) || (op == OP_DIV);
    assign div_op   = (op == OP_DIV) || (op == OP_DIVU);
    assign start    = (state_q == S_IDLE) && (op == OP_MULT || op == OP_MULTU || div_op);
    assign div_zero = div_op && (rt_val == '0);
    assign abs_a    = (sgn_op && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign abs_b    = (sgn_op && rt_val[WIDTH-1]) ? -rt_val : rt_val;

    // Multiply: add multiplicand into the upper half when the LSB is set, then shift right.
    assign mul_sum  = acc_q[AW-1:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_step = {1'b0, mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: shift left, subtract divisor if it fits, shift quotient bit in.
    assign div_hi   = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_step = (div_hi >= {1'b0, opnd_q})
                    ? {div_hi - {1'b0, opnd_q}, acc_q[WIDTH-2:0], 1'b1}
                    : {div_hi, acc_q[WIDTH-2:0], 1'b0};

    assign prod = acc_q[2*WIDTH-1:0];
    assign quo  = acc_q[WIDTH-1:0];
    assign rem  = acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_CALC;
                    cnt_d     = CW'(WIDTH);
                    is_div_d  = div_op;
                    neg_quo_d = sgn_op && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                    neg_rem_d = sgn_op && rs_val[WIDTH-1];
                    dz_d      = div_zero;
                    if (div_op) begin
                        // Raw dividend on divide-by-zero so the remainder comes out as rs_val.
                        acc_d  = {{(WIDTH+1){1'b0}}, div_zero ? rs_val : abs_a};
                        opnd_d = abs_b;
                    end else begin
                        acc_d  = {{(WIDTH+1){1'b0}}, abs_b};
                        opnd_d = abs_a;
                    end
                end else if (op == OP_MTHI) begin
                    hi_d = rs_val;
                end else if (op == OP_MTLO) begin
                    lo_d = rs_val;
                end
            end
            S_CALC: begin
                acc_d = is_div_q ? div_step : mul_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    lo_d = (neg_quo_q && !dz_q) ? -quo : quo;
                    hi_d = (neg_rem_q && !dz_q) ? -rem : rem;
                end else begin
                    {hi_d, lo_d} = neg_quo_q ? -prod : prod;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv at WIDTH=32 and WIDTH=8 with a result scoreboard.
module tb_hilo_muldiv;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val, alu_out, hilo_out;
    logic [1:0]  rd_sel;
    logic        busy, done, stall;

    logic [2:0]  op8;
    logic [7:0]  rs8, rt8, alu8, hilo8;
    logic [1:0]  rd_sel8;
    logic        busy8, done8, stall8;

    int total = 0;
    int bad   = 0;
    logic [63:0] sb[$];

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .op(op), .rs_val(rs_val), .rt_val(rt_val),
        .rd_sel(rd_sel), .alu_out(alu_out), .hilo_out(hilo_out),
        .busy(busy), .done(done), .stall(stall)
    );

    hilo_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .op(op8), .rs_val(rs8), .rt_val(rt8),
        .rd_sel(rd_sel8), .alu_out(alu8), .hilo_out(hilo8),
        .busy(busy8), .done(done8), .stall(stall8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo);
        op     = o;
        rs_val = a;
        rt_val = b;
        sb.push_back({ehi, elo});
    endtask

    // Called in the cycle the op is driven; returns in the done cycle.
    task automatic wait_done(input string tag, input int mode,
                             input logic [31:0] old_hi, input logic [31:0] old_lo);
        int n;
        logic [63:0] e;
        @(posedge clk); #1;
        op = OP_NONE; rs_val = '0; rt_val = '0; rd_sel = 2'd0; #1;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            if (mode == 1) begin
                if (n == 1) begin
                    chk({tag, "_idle_op_nostall"}, 64'(stall), 64'd0);
                end
                if (n == 2) begin
                    rd_sel = 2'd3; alu_out = 32'hDEADBEEF; #1;
                    chk({tag, "_busy_alu_rd3"}, 64'(hilo_out), 64'hDEADBEEF);
                    chk({tag, "_busy_rd3_nostall"}, 64'(stall), 64'd0);
                    rd_sel = 2'd0;
                end
                if (n == 3) begin
                    op = OP_MTHI; rs_val = 32'h1234; #1;
                    chk({tag, "_mthi_stall"}, 64'(stall), 64'd1);
                end
                if (n == 4) begin
                    op = OP_NONE; rs_val = '0; rd_sel = 2'd2; #1;
                    chk({tag, "_mflo_stall"}, 64'(stall), 64'd1);
                    chk({tag, "_mflo_old"}, 64'(hilo_out), 64'(old_lo));
                end
                if (n == 5) begin
                    rd_sel = 2'd1; #1;
                    chk({tag, "_mfhi_old"}, 64'(hilo_out), 64'(old_hi));
                    rd_sel = 2'd0; op = OP_DIVU; rs_val = 32'hA; rt_val = 32'h3; #1;
                    chk({tag, "_divu_stall"}, 64'(stall), 64'd1);
                end
                if (n == 6) begin
                    op = OP_NONE; rs_val = '0; rt_val = '0;
                end
            end
            @(posedge clk); #1;
        end
        chk({tag, "_busy_cycles"}, 64'(n), 64'd33);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_sb_depth"}, 64'(sb.size()), 64'd1);
        e = (sb.size() > 0) ? sb.pop_front() : 64'hX;
        rd_sel = 2'd1; #1;
        chk({tag, "_hi"}, 64'(hilo_out), 64'(e[63:32]));
        rd_sel = 2'd2; #1;
        chk({tag, "_lo"}, 64'(hilo_out), 64'(e[31:0]));
        rd_sel = 2'd0; #1;
        if (mode == 1) begin
            chk({tag, "_done_alu_rd0"}, 64'(hilo_out), 64'hDEADBEEF);
        end
    endtask

    initial begin
        int n;
        int dn;
        logic [63:0] e;
        reset = 1'b1; op = OP_NONE; rs_val = '0; rt_val = '0; rd_sel = 2'd0; alu_out = 32'hCAFE0001;
        op8 = OP_NONE; rs8 = '0; rt8 = '0; rd_sel8 = 2'd0; alu8 = 8'h5A;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        op = OP_MULT; rd_sel = 2'd1; #1;
        chk("rst_stall", 64'(stall), 64'd0);
        op = OP_NONE;
        chk("rst_hi", 64'(hilo_out), 64'd0);
        rd_sel = 2'd2; #1;
        chk("rst_lo", 64'(hilo_out), 64'd0);
        rd_sel = 2'd0; #1;
        chk("rst_alu", 64'(hilo_out), 64'hCAFE0001);
        chk("rst8_alu", 64'(hilo8), 64'h5A);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // MULT with interfering accesses while busy
        start_op(OP_MULT, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA);
        wait_done("mult_neg", 1, 32'h0, 32'h0);

        // MTHI/MTLO in the done cycle, no bypass
        op = OP_MTHI; rs_val = 32'h1234; rd_sel = 2'd1; #1;
        chk("mthi_nostall_idle", 64'(stall), 64'd0);
        chk("mthi_same_cycle_old", 64'(hilo_out), 64'hFFFFFFFF);
        @(posedge clk); #1;
        op = OP_NONE; rs_val = '0; #1;
        chk("done_single_pulse", 64'(done), 64'd0);
        chk("mfhi_after_mthi", 64'(hilo_out), 64'h1234);
        op = OP_MTLO; rs_val = 32'h5678; rd_sel = 2'd2; #1;
        chk("mtlo_same_cycle_old", 64'(hilo_out), 64'hFFFFFFFA);
        @(posedge clk); #1;
        op = OP_NONE; rs_val = '0; #1;
        chk("mflo_after_mtlo", 64'(hilo_out), 64'h5678);
        rd_sel = 2'd0;

        // back-to-back issue from each done cycle
        start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        wait_done("multu_max", 0, '0, '0);
        start_op(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1);
        wait_done("mult_m1m1", 0, '0, '0);
        start_op(OP_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        wait_done("div_neg", 0, '0, '0);
        start_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        wait_done("div_ovf", 0, '0, '0);
        start_op(OP_DIVU, 32'hA, 32'h0, 32'hA, 32'hFFFFFFFF);
        wait_done("divu_zero", 0, '0, '0);
        start_op(OP_DIV, 32'hFFFFFFF0, 32'h0, 32'hFFFFFFF0, 32'hFFFFFFFF);
        wait_done("div_zero_neg", 0, '0, '0);
        start_op(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        wait_done("divu_100_7", 0, '0, '0);

        // reset in the middle of a DIV
        start_op(OP_DIV, 32'd64, 32'd5, 32'd4, 32'd12);
        @(posedge clk); #1;
        op = OP_NONE; rs_val = '0; rt_val = '0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        chk("middiv_busy", 64'(busy), 64'd1);
        reset = 1'b1; #1;
        chk("middiv_rst_busy", 64'(busy), 64'd0);
        rd_sel = 2'd1; #1;
        chk("middiv_rst_hi", 64'(hilo_out), 64'd0);
        rd_sel = 2'd2; #1;
        chk("middiv_rst_lo", 64'(hilo_out), 64'd0);
        rd_sel = 2'd0;
        e = sb.pop_front();
        @(posedge clk); #1;
        reset = 1'b0;
        dn = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) dn++;
        end
        chk("middiv_no_done", 64'(dn), 64'd0);
        chk("middiv_idle", 64'(busy), 64'd0);
        start_op(OP_MULTU, 32'd5, 32'd7, 32'h0, 32'h23);
        wait_done("multu_5x7", 0, '0, '0);

        // narrow instance
        op8 = OP_MULT; rs8 = 8'hFE; rt8 = 8'h03;
        sb.push_back({32'hFF, 32'hFA});
        @(posedge clk); #1;
        op8 = OP_NONE; rs8 = '0; rt8 = '0; #1;
        n = 0;
        while (busy8 === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk("w8_busy_cycles", 64'(n), 64'd9);
        chk("w8_done", 64'(done8), 64'd1);
        chk("w8_stall", 64'(stall8), 64'd0);
        e = (sb.size() > 0) ? sb.pop_front() : 64'hX;
        rd_sel8 = 2'd1; #1;
        chk("w8_hi", 64'(hilo8), 64'(e[63:32]));
        rd_sel8 = 2'd2; #1;
        chk("w8_lo", 64'(hilo8), 64'(e[31:0]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

- Parametrised HI/LO unit for the CPU datapath.
- Contains an iterative multiply/divide engine (signed and unsigned), the HI/LO result registers, MTHI/MTLO writes and the MFHI/MFLO read mux onto the writeback path.
- Multiply and divide are multi-cycle. The block tells the control unit to hold the issuing stage with `busy`, and requests a stall for any HI/LO access made while an operation is in flight.

## Interface

- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits. Must be ≥ 4.
- `clk` in 1: clock. All state updates on the rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `op` in 3: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- `rs_val` in `WIDTH`: first operand; dividend; MTHI/MTLO data.
- `rt_val` in `WIDTH`: second operand; divisor.
- `rd_sel` in 2: 1 = HI, 2 = LO, 0 or 3 = pass `alu_out`.
- `alu_out` in `WIDTH`: ALU result, passed through when not reading HI/LO.
- `hilo_out` out `WIDTH`: writeback value.
- `busy` out 1: engine is in CALC or FIX.
- `done` out 1: one-cycle pulse; HI/LO hold a new mul/div result.
- `stall` out 1: `busy && (op != NONE || rd_sel is 1 or 2)`.

## Operation

- **State machine**: IDLE, CALC, FIX.
  - IDLE → CALC on a clock edge where `busy`=0 and `op` is 1–4. Operands are latched and the cycle counter is loaded with `WIDTH`.
  - CALC performs one iteration per cycle and decrements the counter. CALC → FIX after `WIDTH` iterations.
  - FIX applies the sign correction, writes HI/LO, then goes to IDLE.
- **Signed ops (MULT, DIV)**: absolute values are latched, along with the flags `neg_q = sign(a)^sign(b)` and `neg_r = sign(a)`.
  - MULT in FIX: if `neg_q`, the 2·`WIDTH` product is two's-complement negated.
  - DIV in FIX: if `neg_q`, the quotient is negated; if `neg_r`, the remainder is negated.
  - All arithmetic wraps modulo 2^`WIDTH`. DIV of the most negative value by −1 gives LO = the most negative value and HI = 0.
- **Multiply**: shift-add, LSB first, using a 2·`WIDTH`+1 bit accumulator. Result: HI = product[2W-1:W], LO = product[W-1:0].
- **Divide**: restoring, MSB first. Result: LO = quotient, HI = remainder.
- **Divide by zero** (DIV or DIVU, `rt_val` = 0): the engine still runs the full `WIDTH`+1 cycles. Result: HI = `rs_val`, LO = all ones. No sign fix is applied.
- **MTHI / MTLO**: when `busy`=0, HI or LO is written with `rs_val` on the edge. When `busy`=1 they are ignored; `stall` is high so the CPU reissues them.
- **Mul/div while busy**: a new `op` 1–4 is ignored (not queued) and `stall` is asserted.
- **Read mux**: `hilo_out` is combinational from `rd_sel` and the HI/LO registers or `alu_out`. While `busy`=1, HI/LO still present their old contents.
- **Reset** (including mid-operation): HI=0, LO=0, state IDLE, counter 0, `busy`=0, `done`=0. Any partial result is discarded.

## Timing

- **Reset values**: `busy`=0, `done`=0. `stall` is 0 unless `op`≠NONE is impossible, i.e. `stall`=0 while `busy`=0. `hilo_out` = `alu_out` for `rd_sel`=0, and 0 for `rd_sel`=1 or 2.
- **Mul/div latency**: with start accepted at edge E0, `busy`=1 from E0 to E0+`WIDTH`+1. HI/LO are written at edge E0+`WIDTH`+1.
  - In the cycle after E0+`WIDTH`+1: `busy`=0, `done`=1, and MFHI/MFLO return the new values.
- **MTHI/MTLO latency**: write at the edge. A same-cycle MFHI/MFLO returns the old value; there is no bypass. The following cycle returns the new value.
- **Back-to-back ops**: a new mul/div can be accepted in the `done` cycle. Minimum issue interval is `WIDTH`+2 cycles.
- `stall` is combinational from `busy`, `op` and `rd_sel`.

## Test plan

- Reset, then MULT with `rs_val`=0xFFFFFFFE, `rt_val`=0x00000003 (`WIDTH`=32) → `busy` high for exactly 33 cycles, then `done` pulses once; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
  - MULT of the same operands → HI=0, LO=1.
- DIV 0xFFFFFFF9 / 0x00000002 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU 0x0000000A / 0 → HI=0x0000000A, LO=0xFFFFFFFF.
- During an active MULT:
  - MTHI 0x1234 → ignored, `stall`=1.
  - MFLO (`rd_sel`=2) → `stall`=1, `hilo_out` = old LO.
  - A second DIVU → ignored; the final result matches the MULT only.
  - After `done`, MTHI 0x1234 then MFHI next cycle → `hilo_out`=0x00001234.
- Assert `reset` at cycle 10 of a DIV → HI=LO=0, `busy`=0 immediately.
  - No `done` pulse follows.
  - A fresh MULTU 5×7 afterwards → LO=0x23, HI=0.
- `rd_sel`=0 and 3 with `alu_out`=0xDEADBEEF → `hilo_out`=0xDEADBEEF in every state.
- Repeat the first scenario with `WIDTH`=8 → `busy` lasts 9 cycles.
